instruction_prefetch: RTL

INSTRUCTION_PREFETCH -- requirements
Module: instruction_prefetch

---
 rtl/instruction_prefetch.sv | 123 ++++++++++++
 1 files changed

// File: rtl/instruction_prefetch.sv
// Instruction prefetch unit: keeps up to DEPTH fetched words queued ahead of decode.
// Optional macro PREFETCH_PERF_EN adds a 32-bit fetch_count output of accepted instructions.
module instruction_prefetch #(
  parameter int INST_WIDTH                                  = 32,
  parameter int INST_MEMORY_ADDRESS_WIDTH                   = 32,
  parameter int DEPTH                                       = 4,
  parameter logic [INST_MEMORY_ADDRESS_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  output logic                                 mem_req,
  output logic [INST_MEMORY_ADDRESS_WIDTH-1:0] mem_addr,
  input  logic                                 mem_ack,
  input  logic [INST_WIDTH-1:0]                mem_rdata,
  input  logic                                 redirect_valid,
  input  logic [INST_MEMORY_ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                                 inst_valid,
  input  logic                                 inst_ready,
  output logic [INST_WIDTH-1:0]                inst_data,
  output logic [INST_MEMORY_ADDRESS_WIDTH-1:0] inst_pc
`ifdef PREFETCH_PERF_EN
  ,
  output logic [31:0]                          fetch_count
`endif
);

  localparam int AW    = INST_MEMORY_ADDRESS_WIDTH;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, DISCARD} state_t;

  state_t                state;
  logic [AW-1:0]         fetch_pc;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic [INST_WIDTH-1:0] data_q [DEPTH];
  logic [AW-1:0]         pc_q   [DEPTH];
  logic                  push;
  logic                  pop;
  logic                  issue;

  // Issue only from IDLE, so the in-flight word always has a free slot; a pop
  // in the same cycle frees one early so a full queue refills immediately.
  always_comb begin
    pop        = (count != '0) && inst_ready;
    push       = (state == WAIT_ACK) && mem_ack && !redirect_valid;
    issue      = (state == IDLE) && !redirect_valid && ((count != FULL) || pop);
    inst_valid = (count != '0);
    inst_data  = inst_valid ? data_q[rd_ptr] : '0;
    inst_pc    = inst_valid ? pc_q[rd_ptr]   : '0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr] <= mem_rdata;
      pc_q[wr_ptr]   <= mem_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (redirect_valid) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        fetch_pc <= redirect_pc;
      end else begin
        if (push) begin
          wr_ptr   <= wr_ptr + 1'b1;
          fetch_pc <= fetch_pc + AW'(4);
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (!push && pop) count <= count - 1'b1;
      end

      case (state)
        IDLE: begin
          if (issue) begin
            mem_req  <= 1'b1;
            mem_addr <= fetch_pc;
            state    <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end else if (redirect_valid) begin
            mem_req <= 1'b0;
            state   <= DISCARD;
          end
        end
        DISCARD: begin
          if (mem_ack) state <= IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef PREFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) fetch_count <= '0;
    else if (pop)              fetch_count <= fetch_count + 32'd1;
  end
`endif

endmodule
